// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage widths, reset address and bubble encoding.
package fetch_pkg;
    localparam int DEF_PC_W = 16;
    localparam int DEF_INSTR_W = 24;
    localparam logic [DEF_PC_W-1:0] DEF_RESET_PC = 16'h0000;
    localparam logic [DEF_INSTR_W-1:0] DEF_NOP_INSTR = 24'h000000;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: execute/decode/ROM-side signals of the fetch stage.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int PC_W = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
);
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instr_d;
    logic [PC_W-1:0]    pc_d;
    logic               valid_d;
    logic [15:0]        fetch_count;

    modport master (
        output stall, branch_taken, branch_target, rom_data,
        input  rom_addr, instr_d, pc_d, valid_d, fetch_count
    );
    modport slave (
        input  stall, branch_taken, branch_target, rom_data,
        output rom_addr, instr_d, pc_d, valid_d, fetch_count
    );
endinterface

// File: rtl/fetch_id_reg.sv
// fetch_id_reg: fetch-to-decode pipeline register with hold and flush.
module fetch_id_reg
    import fetch_pkg::*;
#(
    parameter int PC_W = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_flush,
    input  logic               i_hold,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    input  logic               i_vld,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_vld
);
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;
    logic               r_vld;

    // A flush keeps pc so the bubble still carries the last decoded address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= NOP_INSTR;
            r_pc    <= RESET_PC;
            r_vld   <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_vld   <= 1'b0;
        end else if (!i_hold) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_vld   <= i_vld;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_vld   = r_vld;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch from a synchronous ROM with stall hold,
// branch redirect (one bubble) and a delivered-instruction counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input logic    clk,
    input logic    reset,
    fetch_if.slave bus
);
    logic [PC_W-1:0] r_pc_f;
    logic [PC_W-1:0] r_pc_q;
    logic            r_fetch_vld;
    logic [15:0]     r_fetch_count;
    logic [PC_W-1:0] w_rom_addr;
    logic            w_advance;

    assign w_advance = !bus.branch_taken && !bus.stall;

    // While stalled the ROM re-reads pc_q so rom_data stays valid for the held slot.
    assign w_rom_addr = reset            ? RESET_PC :
                        bus.branch_taken ? bus.branch_target :
                        bus.stall        ? r_pc_q : r_pc_f;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_f        <= RESET_PC;
            r_pc_q        <= RESET_PC;
            r_fetch_vld   <= 1'b0;
            r_fetch_count <= 16'h0000;
        end else if (bus.branch_taken) begin
            r_pc_q      <= bus.branch_target;
            r_pc_f      <= bus.branch_target + PC_W'(1);
            r_fetch_vld <= 1'b1;
        end else if (!bus.stall) begin
            r_pc_q        <= r_pc_f;
            r_pc_f        <= r_pc_f + PC_W'(1);
            r_fetch_vld   <= 1'b1;
            r_fetch_count <= r_fetch_count + 16'(r_fetch_vld);
        end
    end

    fetch_id_reg #(
        .PC_W(PC_W),
        .INSTR_W(INSTR_W),
        .RESET_PC(RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) u_id_reg (
        .clk(clk),
        .reset(reset),
        .i_flush(bus.branch_taken),
        .i_hold(!w_advance),
        .i_instr(bus.rom_data),
        .i_pc(r_pc_q),
        .i_vld(r_fetch_vld),
        .o_instr(bus.instr_d),
        .o_pc(bus.pc_d),
        .o_vld(bus.valid_d)
    );

    assign bus.rom_addr    = w_rom_addr;
    assign bus.fetch_count = r_fetch_count;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a delivery-sequence model.
module tb_fetch_unit;
    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [23:0] NOP = 24'h000000;

    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int passed = 0;

    fetch_if #(.PC_W(16), .INSTR_W(24)) bus ();

    fetch_unit dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_fn(input logic [15:0] a);
        return 24'h100000 + {8'h00, a};
    endfunction

    always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

    // Model: after reset/branch, decode receives base, base+1, ... one per non-stall edge.
    logic [23:0] m_instr;
    logic [15:0] m_pc;
    logic        m_valid;
    logic [15:0] m_count;
    logic [15:0] m_base;
    logic [15:0] m_n;
    logic        m_primed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
        logic [15:0] ea;
        reset = r;
        bus.stall = s;
        bus.branch_taken = b;
        bus.branch_target = t;
        #1;
        ea = r ? RST_PC : b ? t : !m_primed ? RST_PC : s ? m_base + m_n : m_base + m_n + 16'd1;
        chk("rom_addr", {16'h0, bus.rom_addr}, {16'h0, ea});
        if (r) begin
            m_instr = NOP; m_pc = RST_PC; m_valid = 1'b0; m_count = 16'h0;
            m_base = RST_PC; m_n = 16'h0; m_primed = 1'b0;
        end else if (b) begin
            m_instr = NOP; m_valid = 1'b0; m_base = t; m_n = 16'h0; m_primed = 1'b1;
        end else if (!s) begin
            if (m_primed) begin
                m_pc = m_base + m_n;
                m_instr = rom_fn(m_pc);
                m_valid = 1'b1;
                m_count = m_count + 16'd1;
                m_n = m_n + 16'd1;
            end else begin
                m_instr = rom_fn(RST_PC); m_pc = RST_PC; m_valid = 1'b0;
                m_base = RST_PC; m_n = 16'h0; m_primed = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("instr_d", {8'h0, bus.instr_d}, {8'h0, m_instr});
        chk("pc_d", {16'h0, bus.pc_d}, {16'h0, m_pc});
        chk("valid_d", {31'h0, bus.valid_d}, {31'h0, m_valid});
        chk("fetch_count", {16'h0, bus.fetch_count}, {16'h0, m_count});
    endtask

    task automatic adv_until(input logic [15:0] pc);
        int k = 0;
        while (!(m_valid && m_pc == pc) && k < 64) begin
            step(1'b0, 1'b0, 1'b0, 16'h0);
            k++;
        end
        chk("adv_until_bound", {31'h0, k < 64}, 32'h1);
    endtask

    initial begin
        m_primed = 1'b0; m_base = RST_PC; m_n = 16'h0;
        reset = 1'b1; bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 16'h0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 16'h0);
        adv_until(16'd5);
        repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("pc_after_stall", {16'h0, bus.pc_d}, 32'd7);
        adv_until(16'd10);
        step(1'b0, 1'b0, 1'b1, 16'h0040);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("branch_target_pc", {16'h0, bus.pc_d}, 32'h40);
        step(1'b0, 1'b1, 1'b1, 16'h0020);
        repeat (2) step(1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("branch_stall_pc", {16'h0, bus.pc_d}, 32'h20);
        step(1'b0, 1'b0, 1'b1, 16'hFFFE);
        repeat (4) step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("wrap_pc", {16'h0, bus.pc_d}, 32'h1);
        adv_until(16'd9);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h0033);
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0);
        repeat (500) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) == 0, 16'($urandom));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter and ROM address width.
REQ-002 SHALL have parameter INSTR_W, default 24, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-004 SHALL have parameter NOP_INSTR, default 24'h000000, bubble encoding.
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port stall  input  1  decode stage cannot accept; hold fetch and decode outputs.
REQ-008 SHALL have port branch_taken  input  1  redirect request from execute.
REQ-009 SHALL have port branch_target  input  PC_W  redirect address.
REQ-010 SHALL have port rom_addr  output  PC_W  instruction ROM address (combinational).
REQ-011 SHALL have port rom_data  input  INSTR_W  ROM read data; synchronous ROM, data for the address presented in cycle n appears in cycle n+1.
REQ-012 SHALL have port instr_d  output  INSTR_W  instruction presented to decode (registered).
REQ-013 SHALL have port pc_d  output  PC_W  address of instr_d (registered).
REQ-014 SHALL have port valid_d  output  1  instr_d is a real instruction, not a bubble.
REQ-015 SHALL have port fetch_count  output  16  count of valid instructions delivered to decode.

Function
REQ-016 SHALL hold internal pc_f (next address to issue), pc_q (address whose data is on rom_data) and fetch_vld (rom_data meaningful).
REQ-017 SHALL apply event priority: reset > branch_taken > stall > advance.
REQ-018 Advance (no stall, no branch): rom_addr = pc_f; at edge pc_q <= pc_f, pc_f <= pc_f+1, {instr_d,pc_d,valid_d} <= {rom_data,pc_q,fetch_vld}, fetch_vld <= 1.
REQ-019 Stall (no branch): rom_addr = pc_q so the ROM re-reads the pending instruction; pc_f, pc_q, fetch_vld, instr_d, pc_d, valid_d and fetch_count all hold.
REQ-020 Branch (overrides stall): rom_addr = branch_target; at edge pc_q <= branch_target, pc_f <= branch_target+1, fetch_vld <= 1, instr_d <= NOP_INSTR, valid_d <= 0; the wrong-path rom_data is discarded.
REQ-021 SHALL deliver the target instruction to decode on the second edge after branch_taken if no stall intervenes (one bubble).
REQ-022 SHALL wrap pc_f and pc_q modulo 2^PC_W (16'hFFFF+1 = 16'h0000) with no flag.
REQ-023 SHALL increment fetch_count only on an advance edge where fetch_vld = 1; fetch_count SHALL wrap modulo 2^16.
REQ-024 SHALL never present a given ROM address to decode twice across a stall, and SHALL never skip one.

Reset
REQ-025 While reset = 1: rom_addr = RESET_PC; at edge pc_f <= RESET_PC, pc_q <= RESET_PC, fetch_vld <= 0, instr_d <= NOP_INSTR, pc_d <= RESET_PC, valid_d <= 0, fetch_count <= 0.
REQ-026 Reset asserted mid-stall or coincident with branch_taken SHALL win; both requests are dropped.
REQ-027 After reset deassertion with no stall: first edge fetches RESET_PC (valid_d still 0); second edge delivers instr at RESET_PC with valid_d = 1, pc_d = RESET_PC.

Structure
REQ-028 SHALL place PC_W, INSTR_W, RESET_PC and NOP_INSTR defaults in shared package fetch_pkg, used by the processor top level.
REQ-029 SHALL implement the decode-side register (instr_d, pc_d, valid_d with hold and flush) as sub-module fetch_id_reg; pc/count logic stays in fetch_unit.

Verification
REQ-030 Reset then ROM[a]=a+24'h100000, no stall: decode shows pc_d 0,1,2,3 with instr_d 24'h100000.. on consecutive cycles, valid_d 0 for the first cycle only.
REQ-031 Stall 3 cycles while pc_d=5: instr_d/pc_d hold at 5 and rom_addr = 6; after release pc_d goes 6,7 with no gap or duplicate; fetch_count unchanged during stall.
REQ-032 branch_taken with target 16'h0040 while pc_d=10: next cycle valid_d=0, instr_d=NOP_INSTR; following cycle pc_d=16'h0040, valid_d=1.
REQ-033 branch_taken and stall together, target 16'h0020: branch wins, bubble inserted, pc_d=16'h0020 after stall drops.
REQ-034 Branch to 16'hFFFE: pc_d sequence FFFE, FFFF, 0000, 0001.
REQ-035 Reset during stall with pc_d=9: next cycle valid_d=0, fetch_count=0, rom_addr=RESET_PC.
